// File: rtl/sirv_gnrl_dffs.sv
// Generic flop cells used by the writeback output stage.
//   sirv_gnrl_dfflr : load-enable flop with asynchronous active-low reset
//                     (lden, dnxt, qout, clk, rst_n)
//   sirv_gnrl_dffl  : load-enable flop without reset
//                     (lden, dnxt, qout, clk)
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk,
  input  logic          rst_n
);
  logic [DW-1:0] qout_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    qout_r <= '0;
    else if (lden) qout_r <= dnxt;
  end

  assign qout = qout_r;
endmodule

module sirv_gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout,
  input  logic          clk
);
  logic [DW-1:0] qout_r;

  always_ff @(posedge clk) begin
    if (lden) qout_r <= dnxt;
  end

  assign qout = qout_r;
endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Writeback arbiter: picks one of the ALU / long-pipe writeback requests per
// cycle and registers it into a one-deep output stage driving the register
// file write port.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   alu_wbck_i_*   (valid/ready/wdat/rdidx)   ALU writeback request
//   longp_wbck_i_* (valid/ready/wdat/rdidx)   LSU/div writeback request
//   rf_wbck_o_ena/rdidx/wdat         registered register-file write port
//   wbck_busy                        accepted write held in the output stage
//
// Build option
//   E203_WBCK_FAIR_EN : after FAIR_LIMIT back-to-back long-pipe grants with
//   the ALU waiting, the ALU gets one grant. Undefined = strict long-pipe
//   priority, no counter.
//
// Widths default from the e203_defines.v macros; fallbacks below keep the
// block self-contained when that file is not in the compile.
`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif
`ifndef E203_WBCK_FAIR_LIMIT
`define E203_WBCK_FAIR_LIMIT 3
`endif

module e203_exu_wbck_arb #(
  parameter int XLEN       = `E203_XLEN,
  parameter int RFIDX_W    = `E203_RFIDX_WIDTH,
  parameter int FAIR_LIMIT = `E203_WBCK_FAIR_LIMIT
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               alu_wbck_i_valid,
  output logic               alu_wbck_i_ready,
  input  logic [XLEN-1:0]    alu_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] alu_wbck_i_rdidx,

  input  logic               longp_wbck_i_valid,
  output logic               longp_wbck_i_ready,
  input  logic [XLEN-1:0]    longp_wbck_i_wdat,
  input  logic [RFIDX_W-1:0] longp_wbck_i_rdidx,

  output logic               rf_wbck_o_ena,
  output logic [RFIDX_W-1:0] rf_wbck_o_rdidx,
  output logic [XLEN-1:0]    rf_wbck_o_wdat,

  output logic               wbck_busy
);

  logic               alu_gnt;
  logic               longp_gnt;
  logic               wbck_hs;
  logic [RFIDX_W-1:0] sel_rdidx;
  logic [XLEN-1:0]    sel_wdat;
  logic               ena_q;
  logic [RFIDX_W-1:0] rdidx_q;
  logic [XLEN-1:0]    wdat_q;

`ifdef E203_WBCK_FAIR_EN
  // Counts long-pipe wins while the ALU is left waiting; the ALU gets the
  // slot once the count reaches FAIR_LIMIT.
  logic [2:0] fair_cnt;
  logic       fair_hit;

  assign fair_hit = (fair_cnt == 3'(FAIR_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                fair_cnt <= '0;
    else if (!alu_wbck_i_valid || alu_gnt)  fair_cnt <= '0;
    else if (longp_gnt)                     fair_cnt <= fair_cnt + 3'd1;
  end

  assign alu_gnt = ~rst & alu_wbck_i_valid & (~longp_wbck_i_valid | fair_hit);
`else
  assign alu_gnt = ~rst & alu_wbck_i_valid & ~longp_wbck_i_valid;
`endif

  assign longp_gnt = ~rst & longp_wbck_i_valid & ~alu_gnt;

  // Output stage never stalls, so ready is simply the grant.
  assign alu_wbck_i_ready   = alu_gnt;
  assign longp_wbck_i_ready = longp_gnt;

  assign wbck_hs   = alu_gnt | longp_gnt;
  assign sel_rdidx = alu_gnt ? alu_wbck_i_rdidx : longp_wbck_i_rdidx;
  assign sel_wdat  = alu_gnt ? alu_wbck_i_wdat  : longp_wbck_i_wdat;

  sirv_gnrl_dfflr #(.DW(1)) u_ena_dff (
    .lden  (1'b1),
    .dnxt  (wbck_hs),
    .qout  (ena_q),
    .clk   (clk),
    .rst_n (~rst)
  );

  sirv_gnrl_dffl #(.DW(RFIDX_W)) u_rdidx_dff (
    .lden (wbck_hs),
    .dnxt (sel_rdidx),
    .qout (rdidx_q),
    .clk  (clk)
  );

  sirv_gnrl_dffl #(.DW(XLEN)) u_wdat_dff (
    .lden (wbck_hs),
    .dnxt (sel_wdat),
    .qout (wdat_q),
    .clk  (clk)
  );

  // Data flops carry no reset; force the port to zero while reset is held.
  assign rf_wbck_o_rdidx = rst ? '0 : rdidx_q;
  assign rf_wbck_o_wdat  = rst ? '0 : wdat_q;

  // Writes to x0 still occupy the stage but never reach the register file.
  assign rf_wbck_o_ena = ena_q & (|rdidx_q);
  assign wbck_busy     = ena_q;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
module tb_e203_exu_wbck_arb;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            alu_v = 1'b0, lp_v = 1'b0;
  logic            alu_rdy, lp_rdy;
  logic [XLEN-1:0] alu_d = '0, lp_d = '0;
  logic [RW-1:0]   alu_i = '0, lp_i = '0;
  logic            ena, busy;
  logic [RW-1:0]   o_idx;
  logic [XLEN-1:0] o_dat;

  always #5 clk = ~clk;

  e203_exu_wbck_arb #(.XLEN(XLEN), .RFIDX_W(RW), .FAIR_LIMIT(3)) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_wbck_i_valid   (alu_v),
    .alu_wbck_i_ready   (alu_rdy),
    .alu_wbck_i_wdat    (alu_d),
    .alu_wbck_i_rdidx   (alu_i),
    .longp_wbck_i_valid (lp_v),
    .longp_wbck_i_ready (lp_rdy),
    .longp_wbck_i_wdat  (lp_d),
    .longp_wbck_i_rdidx (lp_i),
    .rf_wbck_o_ena      (ena),
    .rf_wbck_o_rdidx    (o_idx),
    .rf_wbck_o_wdat     (o_dat),
    .wbck_busy          (busy)
  );

  typedef struct {
    logic av; logic [RW-1:0] ai; logic [XLEN-1:0] ad;
    logic lv; logic [RW-1:0] li; logic [XLEN-1:0] ld;
    logic ar; logic lr;
  } vec_t;

  typedef struct {
    logic ena; logic busy; logic [RW-1:0] idx; logic [XLEN-1:0] dat; logic dchk;
  } exp_t;

  exp_t            sb[$];
  logic [RW-1:0]   m_idx = '0;
  logic [XLEN-1:0] m_dat = '0;
  logic            m_known = 1'b0;
  int              nchk = 0, nerr = 0;
  vec_t            tbl[8];

  function automatic vec_t mk(input logic av, input logic [RW-1:0] ai, input logic [XLEN-1:0] ad,
                              input logic lv, input logic [RW-1:0] li, input logic [XLEN-1:0] ld,
                              input logic ar, input logic lr);
    vec_t v;
    v.av = av; v.ai = ai; v.ad = ad; v.lv = lv; v.li = li; v.ld = ld; v.ar = ar; v.lr = lr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ena", 32'(ena), 32'(e.ena));
      chk("busy", 32'(busy), 32'(e.busy));
      if (e.dchk) begin
        chk("rdidx", 32'(o_idx), 32'(e.idx));
        chk("wdat", o_dat, e.dat);
      end
    end
  endtask

  // One cycle: check the previous cycle's writeback, drive, check readies,
  // push the expected output for the next cycle.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    check_out();
    alu_v = v.av; alu_i = v.ai; alu_d = v.ad;
    lp_v  = v.lv; lp_i  = v.li; lp_d  = v.ld;
    #1;
    chk("alu_ready", 32'(alu_rdy), 32'(v.ar));
    chk("longp_ready", 32'(lp_rdy), 32'(v.lr));
    e.ena = 1'b0; e.busy = 1'b0;
    if (v.av && v.ar) begin
      m_idx = v.ai; m_dat = v.ad; m_known = 1'b1; e.busy = 1'b1; e.ena = (v.ai != 0);
    end else if (v.lv && v.lr) begin
      m_idx = v.li; m_dat = v.ld; m_known = 1'b1; e.busy = 1'b1; e.ena = (v.li != 0);
    end
    e.idx = m_idx; e.dat = m_dat; e.dchk = m_known;
    sb.push_back(e);
  endtask

  vec_t idle;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0] = mk(1, 5, 32'h1234_5678, 0, 0, 0, 1, 0);            // ALU only
    tbl[1] = idle;                                               // hold
    tbl[2] = mk(0, 0, 0, 1, 9, 32'hA5A5_0F0F, 0, 1);            // longp only
    tbl[3] = mk(1, 3, 32'h3333_3333, 1, 4, 32'h4444_4444, 0, 1); // both: longp wins
    tbl[4] = mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);            // x0 write
    tbl[5] = idle;
    tbl[6] = mk(1, 31, 32'hDEAD_BEEF, 0, 0, 0, 1, 0);
    tbl[7] = mk(1, 8, 32'h8888_0000, 1, 17, 32'h1717_1717, 0, 1);

    // Reset state with both sources requesting.
    alu_v = 1'b1; lp_v = 1'b1; alu_i = 5'd2; lp_i = 5'd3;
    repeat (2) @(negedge clk);
    chk("rst_ena", 32'(ena), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdidx", 32'(o_idx), 0);
    chk("rst_wdat", o_dat, 0);
    chk("rst_alu_ready", 32'(alu_rdy), 0);
    chk("rst_longp_ready", 32'(lp_rdy), 0);
    alu_v = 1'b0; lp_v = 1'b0;
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i]);
    step(idle);

    // Both valid for 20 cycles.
    for (int i = 0; i < 20; i++) begin
`ifdef E203_WBCK_FAIR_EN
      step(mk(1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1, 5'(i + 2), 32'hB000_0000 + 32'(i),
              (i % 4) == 3, (i % 4) != 3));
`else
      step(mk(1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1, 5'(i + 2), 32'hB000_0000 + 32'(i), 0, 1));
`endif
    end
    step(idle);

    // Alternating single-source writes to x1..x31.
    for (int r = 1; r < 32; r++) begin
      if (r % 2) step(mk(1, 5'(r), 32'h0100_0000 * 32'(r) + 32'(r), 0, 0, 0, 1, 0));
      else       step(mk(0, 0, 0, 1, 5'(r), 32'hC000_0000 | 32'(r), 0, 1));
    end
    step(idle);

    // Reset lands after a longp handshake but before the capturing edge.
    @(negedge clk);
    check_out();
    lp_v = 1'b1; lp_i = 5'd7; lp_d = 32'h7777_7777;
    #1 chk("mid_longp_ready", 32'(lp_rdy), 1);
    #2 rst = 1'b1;
    #1 chk("mid_rst_longp_ready", 32'(lp_rdy), 0);
    chk("mid_rst_ena", 32'(ena), 0);
    @(negedge clk);
    chk("mid_rst_ena2", 32'(ena), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rdidx", 32'(o_idx), 0);
    lp_v = 1'b0;
    rst = 1'b0;
    m_known = 1'b0;
    step(idle);
    step(idle);
    step(idle);
    step(mk(1, 12, 32'h0000_C0DE, 0, 0, 0, 1, 0));
    step(idle);
    @(negedge clk);
    check_out();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
